sram_param_clr: RTL and testbench

SRAM_PARAM_CLR -- requirements
Module: sram_param_clr

---
 rtl/sram_pkg.sv | 15 +
 rtl/sram_if.sv | 30 +++
 rtl/sram_clr_ctrl.sv | 51 +++++
 rtl/sram_param_clr.sv | 102 ++++++++++
 tb/tb_sram_param_clr.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared types and default geometry for the clearable single-port SRAM.
// Holds the clear-engine state encoding and default DW/AW/LANES values.
// No logic; imported by the interface, the clear controller and the top.
package sram_pkg;

    localparam int DW_DEF    = 24;
    localparam int AW_DEF    = 12;
    localparam int LANES_DEF = 3;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

endpackage

// File: rtl/sram_if.sv
// Access bus for sram_param_clr: request side driven by the master,
// status/read-data side driven by the memory (slave).
// Signals: wr_en_i, rd_en_i, addr_i, wdata_i, wmask_i, clr_req_i -> slave;
//          busy_o, rdata_o, rvalid_o, err_o -> master.
interface sram_if import sram_pkg::*; #(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int LANES = LANES_DEF
);
    logic             wr_en_i;
    logic             rd_en_i;
    logic [AW-1:0]    addr_i;
    logic [DW-1:0]    wdata_i;
    logic [LANES-1:0] wmask_i;
    logic             clr_req_i;
    logic             busy_o;
    logic [DW-1:0]    rdata_o;
    logic             rvalid_o;
    logic             err_o;

    modport slave (
        input  wr_en_i, rd_en_i, addr_i, wdata_i, wmask_i, clr_req_i,
        output busy_o, rdata_o, rvalid_o, err_o
    );

    modport master (
        output wr_en_i, rd_en_i, addr_i, wdata_i, wmask_i, clr_req_i,
        input  busy_o, rdata_o, rvalid_o, err_o
    );
endinterface

// File: rtl/sram_clr_ctrl.sv
// Clear engine: walks clr_cnt over every word, one per cycle, then idles.
// Latency: clr_req_i in IDLE enters CLEAR at the next edge; a clear lasts 2**AW cycles.
// Backpressure: busy_o (registered) is high for every CLEAR cycle; requests during CLEAR are ignored.
// Ports: clk_i, rst_i (async, active-low), clr_req_i in; busy_o, clr_cnt_o out.
module sram_clr_ctrl import sram_pkg::*; #(
    parameter int AW = AW_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_req_i,
    output logic          busy_o,
    output logic [AW-1:0] clr_cnt_o
);
    localparam logic [AW-1:0] LAST_WORD = {AW{1'b1}};

    state_t        r_state;
    logic [AW-1:0] r_clr_cnt;
    logic          r_busy;

    // busy is kept as its own register so it can leave the block as a flop output.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (r_clr_cnt == LAST_WORD) begin
                        r_state   <= IDLE;
                        r_clr_cnt <= '0;
                        r_busy    <= 1'b0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (clr_req_i) begin
                        r_state   <= CLEAR;
                        r_clr_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy_o    = r_busy;
    assign clr_cnt_o = r_clr_cnt;

endmodule

// File: rtl/sram_param_clr.sv
// Single-port SRAM with per-lane write mask and a self-clearing engine.
// Latency: read data 1 cycle after the request (2 with SRAM_OUT_REG_EN); err_o/rvalid_o aligned.
// Backpressure: accesses while busy_o=1 are dropped and flagged on err_o.
// Ports: clk_i, rst_i (async, active-low), bus (sram_if.slave).
// Build option: define SRAM_OUT_REG_EN for an extra output register stage.
module sram_param_clr import sram_pkg::*; #(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int LANES = LANES_DEF
) (
    input  logic  clk_i,
    input  logic  rst_i,
    sram_if.slave bus
);
    localparam int DEPTH = 2**AW;
    localparam int LW    = DW / LANES;

    logic [DW-1:0] r_mem [DEPTH];

    logic          w_busy;
    logic [AW-1:0] w_clr_cnt;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic          w_reject;

    sram_clr_ctrl #(.AW(AW)) u_clr_ctrl (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_req_i (bus.clr_req_i),
        .busy_o    (w_busy),
        .clr_cnt_o (w_clr_cnt)
    );

    // Write wins a same-cycle collision; the read is dropped and reported.
    assign w_wr_acc = bus.wr_en_i & ~w_busy;
    assign w_rd_acc = bus.rd_en_i & ~bus.wr_en_i & ~w_busy;
    assign w_reject = w_busy ? (bus.wr_en_i | bus.rd_en_i)
                             : (bus.wr_en_i & bus.rd_en_i);

    // Array has no reset: the clear engine is the only way it gets zeroed.
    always_ff @(posedge clk_i) begin
        if (w_busy) begin
            r_mem[w_clr_cnt] <= '0;
        end else if (w_wr_acc) begin
            for (int k = 0; k < LANES; k++) begin
                if (bus.wmask_i[k]) begin
                    r_mem[bus.addr_i][k*LW +: LW] <= bus.wdata_i[k*LW +: LW];
                end
            end
        end
    end

    logic [DW-1:0] r_rdata;
    logic          r_rvalid;
    logic          r_err;

    // rdata only loads on an accepted read, so it holds between reads.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_rd_acc;
            r_err    <= w_reject;
            if (w_rd_acc) begin
                r_rdata <= r_mem[bus.addr_i];
            end
        end
    end

`ifdef SRAM_OUT_REG_EN
    logic [DW-1:0] r_rdata_q;
    logic          r_rvalid_q;
    logic          r_err_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rdata_q  <= '0;
            r_rvalid_q <= 1'b0;
            r_err_q    <= 1'b0;
        end else begin
            r_rvalid_q <= r_rvalid;
            r_err_q    <= r_err;
            if (r_rvalid) begin
                r_rdata_q <= r_rdata;
            end
        end
    end

    assign bus.rdata_o  = r_rdata_q;
    assign bus.rvalid_o = r_rvalid_q;
    assign bus.err_o    = r_err_q;
`else
    assign bus.rdata_o  = r_rdata;
    assign bus.rvalid_o = r_rvalid;
    assign bus.err_o    = r_err;
`endif

    assign bus.busy_o = w_busy;

endmodule

// File: tb/tb_sram_param_clr.sv
// Directed bench for sram_param_clr with AW=4 (16 words), DW=24, LANES=3.
// Table of single-access vectors plus hand sequences for clear, reject and reset.
// Read latency follows SRAM_OUT_REG_EN.
module tb_sram_param_clr;

    localparam int DW    = 24;
    localparam int AW    = 4;
    localparam int LANES = 3;
    localparam int DEPTH = 16;
`ifdef SRAM_OUT_REG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sram_if #(.DW(DW), .AW(AW), .LANES(LANES)) sif ();

    sram_param_clr #(.DW(DW), .AW(AW), .LANES(LANES)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (sif.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic             wr;
        logic             rd;
        logic [AW-1:0]    addr;
        logic [DW-1:0]    wdata;
        logic [LANES-1:0] wmask;
        logic [DW-1:0]    exp_rdata;
        logic             exp_rvalid;
        logic             exp_err;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic rd, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic [LANES-1:0] m,
                                input logic [DW-1:0] er, input logic ev, input logic ee);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = a; v.wdata = d; v.wmask = m;
        v.exp_rdata = er; v.exp_rvalid = ev; v.exp_err = ee;
        return v;
    endfunction

    task automatic idle_inputs();
        sif.wr_en_i   = 1'b0;
        sif.rd_en_i   = 1'b0;
        sif.addr_i    = '0;
        sif.wdata_i   = '0;
        sif.wmask_i   = '0;
        sif.clr_req_i = 1'b0;
    endtask

    // Called just after a negedge; drives one access, checks outputs at the
    // latency point, then checks that rvalid/err were single-cycle pulses.
    task automatic do_op(input vec_t v, input string tag);
        sif.wr_en_i = v.wr;
        sif.rd_en_i = v.rd;
        sif.addr_i  = v.addr;
        sif.wdata_i = v.wdata;
        sif.wmask_i = v.wmask;
        @(negedge clk);
        idle_inputs();
        repeat (RD_LAT - 1) @(negedge clk);
        chk({tag, ".rvalid"}, 32'(sif.rvalid_o), 32'(v.exp_rvalid));
        chk({tag, ".err"},    32'(sif.err_o),    32'(v.exp_err));
        chk({tag, ".rdata"},  32'(sif.rdata_o),  32'(v.exp_rdata));
        @(negedge clk);
        chk({tag, ".rvalid_end"}, 32'(sif.rvalid_o), 32'd0);
        chk({tag, ".err_end"},    32'(sif.err_o),    32'd0);
    endtask

    // Counts edges from the current CLEAR state (clr_cnt=0) until busy drops.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (!sif.busy_o) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        vecs[0]  = mk(1'b0, 1'b1, 4'd0,  24'h000000, 3'b000, 24'h000000, 1'b1, 1'b0);
        vecs[1]  = mk(1'b0, 1'b1, 4'd15, 24'h000000, 3'b000, 24'h000000, 1'b1, 1'b0);
        vecs[2]  = mk(1'b1, 1'b0, 4'd5,  24'hABCDEF, 3'b111, 24'h000000, 1'b0, 1'b0);
        vecs[3]  = mk(1'b1, 1'b0, 4'd5,  24'h123456, 3'b010, 24'h000000, 1'b0, 1'b0);
        vecs[4]  = mk(1'b0, 1'b1, 4'd5,  24'h000000, 3'b000, 24'hAB34EF, 1'b1, 1'b0);
        vecs[5]  = mk(1'b1, 1'b0, 4'd6,  24'h998877, 3'b000, 24'hAB34EF, 1'b0, 1'b0);
        vecs[6]  = mk(1'b0, 1'b1, 4'd6,  24'h000000, 3'b000, 24'h000000, 1'b1, 1'b0);
        vecs[7]  = mk(1'b1, 1'b1, 4'd7,  24'h000011, 3'b111, 24'h000000, 1'b0, 1'b1);
        vecs[8]  = mk(1'b0, 1'b1, 4'd7,  24'h000000, 3'b000, 24'h000011, 1'b1, 1'b0);
        vecs[9]  = mk(1'b1, 1'b0, 4'd9,  24'hFFFFFF, 3'b101, 24'h000011, 1'b0, 1'b0);
        vecs[10] = mk(1'b0, 1'b1, 4'd9,  24'h000000, 3'b000, 24'hFF00FF, 1'b1, 1'b0);
        vecs[11] = mk(1'b1, 1'b0, 4'd9,  24'h00AA00, 3'b100, 24'hFF00FF, 1'b0, 1'b0);
        vecs[12] = mk(1'b0, 1'b1, 4'd9,  24'h000000, 3'b000, 24'h0000FF, 1'b1, 1'b0);
        vecs[13] = mk(1'b0, 1'b0, 4'd9,  24'h000000, 3'b000, 24'h0000FF, 1'b0, 1'b0);

        // Reset values and the post-reset clear.
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.busy",   32'(sif.busy_o),   32'd1);
        chk("rst.rvalid", 32'(sif.rvalid_o), 32'd0);
        chk("rst.err",    32'(sif.err_o),    32'd0);
        chk("rst.rdata",  32'(sif.rdata_o),  32'd0);
        rst_n = 1'b1;
        count_busy(n);
        chk("rst_clear.cycles", 32'(n), 32'(DEPTH));
        for (int a = 0; a < DEPTH; a++) begin
            do_op(mk(1'b0, 1'b1, AW'(a), '0, '0, '0, 1'b1, 1'b0), $sformatf("zero_rd%0d", a));
        end

        // Table of single accesses.
        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Read of an address written on the previous cycle.
        sif.wr_en_i = 1'b1; sif.addr_i = 4'd2; sif.wdata_i = 24'h5A5A5A; sif.wmask_i = 3'b111;
        @(negedge clk);
        idle_inputs();
        sif.rd_en_i = 1'b1; sif.addr_i = 4'd2;
        @(negedge clk);
        idle_inputs();
        repeat (RD_LAT - 1) @(negedge clk);
        chk("b2b.rvalid", 32'(sif.rvalid_o), 32'd1);
        chk("b2b.rdata",  32'(sif.rdata_o),  32'h5A5A5A);
        @(negedge clk);

        // Clear request; a write and a second clear request land mid-clear.
        sif.clr_req_i = 1'b1;
        @(negedge clk);
        idle_inputs();
        chk("clr.busy_start", 32'(sif.busy_o), 32'd1);
        n = 0;
        for (int i = 1; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (i == 8 + RD_LAT) chk("busy_rej.err",     32'(sif.err_o), 32'd1);
            if (i == 9 + RD_LAT) chk("busy_rej.err_end", 32'(sif.err_o), 32'd0);
            if (i == 8) begin
                sif.wr_en_i = 1'b1; sif.addr_i = 4'd3; sif.wdata_i = 24'hFFFFFF;
                sif.wmask_i = 3'b111; sif.clr_req_i = 1'b1;
            end
            if (i == 9) idle_inputs();
            if (!sif.busy_o) break;
        end
        chk("clr.cycles", 32'(n), 32'(DEPTH));
        do_op(mk(1'b0, 1'b1, 4'd3, '0, '0, 24'h000000, 1'b1, 1'b0), "busy_rej.rd3");
        do_op(mk(1'b1, 1'b0, 4'd1, 24'h777777, 3'b111, 24'h000000, 1'b0, 1'b0), "pre_rst.wr1");
        do_op(mk(1'b0, 1'b1, 4'd1, '0, '0, 24'h777777, 1'b1, 1'b0), "pre_rst.rd1");

        // Reset pulsed at clr_cnt=9 restarts the clear from word 0.
        sif.clr_req_i = 1'b1;
        @(negedge clk);
        idle_inputs();
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst.busy",   32'(sif.busy_o),   32'd1);
        chk("mid_rst.rdata",  32'(sif.rdata_o),  32'd0);
        chk("mid_rst.rvalid", 32'(sif.rvalid_o), 32'd0);
        chk("mid_rst.err",    32'(sif.err_o),    32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_busy(n);
        chk("mid_rst.cycles", 32'(n), 32'(DEPTH));
        do_op(mk(1'b0, 1'b1, 4'd1, '0, '0, 24'h000000, 1'b1, 1'b0), "post_rst.rd1");
        do_op(mk(1'b0, 1'b1, 4'd9, '0, '0, 24'h000000, 1'b1, 1'b0), "post_rst.rd9");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
